// File: rtl/fsm_pkg.sv
// Shared types for the requester: FSM state encoding and the result record.
// Single-cycle helper computes the value a conforming responder must return.
package fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } req_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       mismatch;
    logic       timeout;
  } res_rec_t;

  localparam int RES_REC_W = $bits(res_rec_t);

  // Responder contract: low three operand bits plus one, wrapping 7 -> 0.
  function automatic logic [7:0] expected_rsp(input logic [2:0] op_lo);
    return {5'b0, op_lo + 3'd1};
  endfunction

endpackage

// File: rtl/fsm_requester_if.sv
// Request/responder/result bundle between the requester and its environment.
// Combinational req_ready; other requester outputs come straight from registers.
interface fsm_requester_if;

  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic       rsp_start;
  logic [7:0] rsp_in;
  logic [7:0] rsp_out;
  logic       rsp_done;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_mismatch;
  logic       res_timeout;
  logic       busy;
  logic       spurious;

  modport master (
    input  req_valid, req_data, rsp_out, rsp_done, res_ready,
    output req_ready, rsp_start, rsp_in, res_valid, res_data,
           res_mismatch, res_timeout, busy, spurious
  );

  modport slave (
    output req_valid, req_data, rsp_out, rsp_done, res_ready,
    input  req_ready, rsp_start, rsp_in, res_valid, res_data,
           res_mismatch, res_timeout, busy, spurious
  );

endinterface

// File: rtl/fsm_result_fifo.sv
// Result queue: push lands at the clock edge, head visible the next cycle, pop on pop_i.
// Backpressure via full_o; head data forced to zero while empty.
module fsm_result_fifo
  import fsm_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = RES_REC_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         head_vld_o,
  output logic [W-1:0] head_dat_o,
  output logic         full_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push_i && (cnt_q != FULL_CNT);
  assign do_pop  = pop_i && (cnt_q != '0);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage needs no reset: an empty queue masks whatever it holds.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_vld_o = (cnt_q != '0);
  assign head_dat_o = head_vld_o ? mem_q[rd_ptr_q] : '0;
  assign full_o     = (cnt_q == FULL_CNT);

endmodule

// File: rtl/fsm_requester.sv
// Issues one request at a time to a responder and queues {result, mismatch, timeout}.
// Accept->result 4 cycles nominal; req_ready drops while busy or the result queue is full.
module fsm_requester
  import fsm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int RES_DEPTH      = 4
) (
  input logic            clk,
  input logic            reset,
  fsm_requester_if.master bus
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  req_state_t state_q;
  logic [7:0] op_q;
  logic [7:0] cnt_q;
  logic       rsp_start_q;
  logic       spurious_q;

  logic       accept_d, push_d, pop_d;
  logic       fifo_full, head_vld;
  logic [7:0] exp_d;
  res_rec_t   rec_d, head;

  assign bus.req_ready = (state_q == IDLE) && !fifo_full;
  assign accept_d      = bus.req_valid && bus.req_ready;
  assign exp_d         = expected_rsp(op_q[2:0]);

  // A response on the last allowed WAIT cycle beats the timeout.
  always_comb begin
    push_d = 1'b0;
    rec_d  = '0;
    if (state_q == WAIT) begin
      if (bus.rsp_done) begin
        push_d         = 1'b1;
        rec_d.data     = bus.rsp_out;
        rec_d.mismatch = (bus.rsp_out != exp_d);
      end else if (cnt_q == TO_LAST) begin
        push_d        = 1'b1;
        rec_d.timeout = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      rsp_start_q <= 1'b0;
      spurious_q  <= 1'b0;
    end else begin
      rsp_start_q <= 1'b0;
      if (bus.rsp_done && (state_q == IDLE || state_q == ISSUE)) begin
        spurious_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            op_q        <= bus.req_data;
            rsp_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (push_d) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pop_d = head_vld && bus.res_ready;

  fsm_result_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (RES_REC_W)
  ) u_res_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push_d),
    .push_dat_i (rec_d),
    .pop_i      (pop_d),
    .head_vld_o (head_vld),
    .head_dat_o (head),
    .full_o     (fifo_full)
  );

  assign bus.rsp_start    = rsp_start_q;
  assign bus.rsp_in       = (state_q == ISSUE || state_q == WAIT) ? op_q : 8'h00;
  assign bus.busy         = (state_q != IDLE);
  assign bus.spurious     = spurious_q;
  assign bus.res_valid    = head_vld;
  assign bus.res_data     = head.data;
  assign bus.res_mismatch = head.mismatch;
  assign bus.res_timeout  = head.timeout;

endmodule

// File: tb/tb_fsm_requester.sv
// Directed bench for fsm_requester: behavioural responder plus an expected-result queue.
module tb_fsm_requester;

  logic clk;
  logic reset;

  fsm_requester_if bus ();

  fsm_requester #(
    .TIMEOUT_CYCLES (15),
    .RES_DEPTH      (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] sb[$];

  // Responder: rsp_done for one cycle rsp_lat cycles after rsp_start (0 = silent).
  int         rsp_lat     = 2;
  bit         bad_mode    = 1'b0;
  bit         force_done  = 1'b0;
  int         cd          = 0;
  logic [7:0] rop         = 8'h00;
  logic       resp_done_r = 1'b0;
  logic [7:0] resp_out_r  = 8'h00;

  assign bus.rsp_done = resp_done_r | force_done;
  assign bus.rsp_out  = resp_out_r;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (reset) begin
      cd = 0;
    end else begin
      if (cd != 0) cd = cd - 1;
      if (bus.rsp_start === 1'b1 && rsp_lat != 0) begin
        cd  = rsp_lat + 1;
        rop = bus.rsp_in;
      end
    end
    resp_done_r = (cd == 1);
    if (!resp_done_r)  resp_out_r = 8'h00;
    else if (bad_mode) resp_out_r = 8'h03;
    else               resp_out_r = {5'b0, rop[2:0] + 3'd1};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    bit ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    for (int i = 0; i < 32; i++) begin
      if (bus.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, 32'(ok), 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    int i = 0;
    while (bus.res_valid !== 1'b1 && i < 64) begin
      @(negedge clk);
      i++;
    end
    e = (sb.size() != 0) ? sb.pop_front() : 10'h3FF;
    chk(tag, 32'({bus.res_valid, bus.res_data, bus.res_mismatch, bus.res_timeout}), 32'({1'b1, e}));
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_data  = 8'h00;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'({bus.rsp_start, bus.rsp_in, bus.busy, bus.res_valid, bus.res_data,
                             bus.res_mismatch, bus.res_timeout, bus.req_ready, bus.spurious}),
        32'h2);
    reset = 1'b0;

    // Nominal latency: accept N, start N+1, done N+3, result N+4.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h05;
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    sb.push_back({8'h06, 2'b00});
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("t1_issue", 32'({bus.rsp_start, bus.rsp_in, bus.busy}), 32'({1'b1, 8'h05, 1'b1}));
    @(negedge clk);
    chk("t1_start_one_cycle", 32'({bus.rsp_start, bus.res_valid, bus.busy}), 32'h1);
    @(negedge clk);
    chk("t1_no_result_n3", 32'(bus.res_valid), 32'h0);
    @(negedge clk);
    chk("t1_idle_n4", 32'({bus.busy, bus.rsp_in}), 32'h0);
    pop_check("t1_result");

    // Expected-value wrap.
    send(8'h07, "t2_accept_07");
    sb.push_back({8'h00, 2'b00});
    pop_check("t2_wrap_07");
    send(8'hFF, "t2_accept_ff");
    sb.push_back({8'h00, 2'b00});
    pop_check("t2_wrap_ff");

    // Silent responder: timeout entry decided 15 cycles after rsp_start.
    rsp_lat = 0;
    send(8'h05, "t3_accept");
    sb.push_back({8'h00, 2'b01});
    chk("t3_start", 32'(bus.rsp_start), 32'h1);
    repeat (14) @(negedge clk);
    chk("t3_s14", 32'({bus.res_valid, bus.busy}), 32'h1);
    @(negedge clk);
    chk("t3_s15", 32'({bus.res_valid, bus.busy}), 32'h1);
    @(negedge clk);
    chk("t3_busy_fall", 32'(bus.busy), 32'h0);
    pop_check("t3_timeout_entry");

    // Response on the final allowed cycle beats the timeout.
    rsp_lat = 15;
    send(8'h02, "t4_accept");
    sb.push_back({8'h03, 2'b00});
    repeat (15) @(negedge clk);
    chk("t4_s15", 32'({bus.res_valid, bus.busy}), 32'h1);
    @(negedge clk);
    pop_check("t4_done_wins");
    rsp_lat = 2;

    // Wrong responder value.
    bad_mode = 1'b1;
    send(8'h05, "t5_accept_05");
    sb.push_back({8'h03, 2'b10});
    pop_check("t5_mismatch");
    send(8'h02, "t5_accept_02");
    sb.push_back({8'h03, 2'b00});
    pop_check("t5_match_by_chance");
    bad_mode = 1'b0;

    // Fill the queue, then a fifth request waits for a pop.
    send(8'h10, "t6_acc0");
    sb.push_back({8'h01, 2'b00});
    send(8'h11, "t6_acc1");
    sb.push_back({8'h02, 2'b00});
    send(8'h12, "t6_acc2");
    sb.push_back({8'h03, 2'b00});
    send(8'h13, "t6_acc3");
    sb.push_back({8'h04, 2'b00});
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h14;
    repeat (8) @(negedge clk);
    chk("t6_full_blocks", 32'({bus.req_ready, bus.busy, bus.res_valid}), 32'h1);
    pop_check("t6_pop0");
    chk("t6_fifth_ready", 32'(bus.req_ready), 32'h1);
    sb.push_back({8'h05, 2'b00});
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("t6_fifth_issue", 32'({bus.rsp_start, bus.rsp_in}), 32'({1'b1, 8'h14}));
    repeat (4) @(negedge clk);
    pop_check("t6_pop1");
    pop_check("t6_pop2");
    pop_check("t6_pop3");
    pop_check("t6_pop4");
    chk("t6_drained", 32'(bus.res_valid), 32'h0);

    // Spurious rsp_done while idle is sticky.
    chk("t7_spurious_clear", 32'(bus.spurious), 32'h0);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    chk("t7_spurious_set", 32'(bus.spurious), 32'h1);
    repeat (3) @(negedge clk);
    chk("t7_spurious_sticky", 32'(bus.spurious), 32'h1);

    // Reset mid-WAIT with one entry already queued.
    send(8'h01, "t8_accept_pre");
    repeat (4) @(negedge clk);
    chk("t8_pre_entry", 32'(bus.res_valid), 32'h1);
    send(8'h05, "t8_accept");
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t8_async_reset", 32'({bus.rsp_start, bus.rsp_in, bus.busy, bus.res_valid, bus.res_data,
                                bus.res_mismatch, bus.res_timeout, bus.req_ready, bus.spurious}),
        32'h2);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("t8_no_entry", 32'({bus.res_valid, bus.busy, bus.spurious}), 32'h0);
    force_done = 1'b1;
    @(negedge clk);
    force_done = 1'b0;
    chk("t8_post_reset_spurious", 32'(bus.spurious), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
